// File: rtl/mult_dot_accum.sv
// mult_dot_accum: dot-product stage behind the 4x4 multiplier core.
// Operand pairs arrive on a valid/ready port. Each pair is multiplied by the
// core and registered. LEN consecutive products are summed modulo 2^ACC_W.
// The sum is then held on a valid/ready result port until it is consumed.
// ovf reports that a carry out of the accumulator was lost in the block.

// main: combinational 4x4 unsigned multiplier core (shift-and-add array).
module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    logic [7:0] pp0;
    logic [7:0] pp1;
    logic [7:0] pp2;
    logic [7:0] pp3;

    // One partial product per multiplier bit, pre-shifted into position.
    assign pp0 = y[0] ? {4'b0000, x}        : 8'd0;
    assign pp1 = y[1] ? {3'b000, x, 1'b0}   : 8'd0;
    assign pp2 = y[2] ? {2'b00, x, 2'b00}   : 8'd0;
    assign pp3 = y[3] ? {1'b0, x, 3'b000}   : 8'd0;

    // 15*15 = 225 is the largest product, so 8 bits never overflow.
    assign o = pp0 + pp1 + pp2 + pp3;
endmodule

module mult_dot_accum #(
    parameter int LEN   = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       x,
    input  logic [3:0]       y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             ovf
);
    localparam int CNT_W = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         core_o;
    logic [7:0]         prod_q;
    logic               pv;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic               ovf_acc;

    logic               accept;
    logic               last;
    logic               abort;
    logic               handshake;
    logic [ACC_W:0]     sum;

    main u_core (
        .x (x),
        .y (y),
        .o (core_o)
    );

    // in_ready is forced low during reset and on an abort, so an aborting
    // cycle can never accept a pair.
    assign in_ready  = (state == ACC) && !clr && rst_n;
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CNT_W'(LEN - 1));
    // clr has no effect in HOLD: a completed result always drains via handshake.
    assign abort     = clr && (state != HOLD);
    assign handshake = (state == HOLD) && out_ready;

    // One extra bit keeps the carry that the wrapped sum would lose.
    assign sum = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod_q};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: count LEN accepts, drain one cycle, hold for consumer.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        unique case (state)
            ACC: begin
                if (accept && last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = clr ? ACC : HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    // Product pipeline register and per-block pair counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= 8'd0;
            pv     <= 1'b0;
            cnt    <= '0;
        end else begin
            // accept is already low on an abort, so this also clears pv there.
            pv <= accept;
            if (accept) begin
                prod_q <= core_o;
            end
            if (abort || handshake) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Running sum with a sticky record of any carry lost from the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (abort || handshake) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (pv) begin
            acc     <= sum[ACC_W-1:0];
            ovf_acc <= ovf_acc | sum[ACC_W];
        end
    end

    // Result register: loaded in DRAIN with the final product folded in,
    // then held stable until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf       <= 1'b0;
        end else if ((state == DRAIN) && !clr) begin
            out_valid <= 1'b1;
            out_data  <= sum[ACC_W-1:0];
            ovf       <= ovf_acc | sum[ACC_W];
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end
endmodule
